// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: instruction width,
// the NOP read-back word and the loader FSM state encoding.
package imem_loader_pkg;

  localparam int unsigned INSTR_W = 17;

  typedef logic [INSTR_W-1:0] instr_t;

  localparam instr_t NOP_WORD = '0;

  typedef enum logic [1:0] {
    ST_B0  = 2'd0,
    ST_B1  = 2'd1,
    ST_B2  = 2'd2,
    ST_RUN = 2'd3
  } ld_state_e;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: DEPTH x 17, one synchronous write port and one
// asynchronous read port. Contents are never reset.
module imem_array
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  instr_t        wdata_i,
  input  logic [AW-1:0] raddr_i,
  output instr_t        rdata_o
);

  instr_t mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Boot loader: assembles 3-byte groups into 17-bit instruction words, writes
// them to imem_array, then releases the CPU hold and serves instruction reads.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [15:0]        imemaddr,
  output logic [INSTR_W-1:0] imemrdata,
  input  logic [7:0]         ld_data,
  input  logic               ld_valid,
  input  logic               ld_last,
  output logic               ld_ready,
  output logic               cpu_hold,
  output logic [AW:0]        ld_count,
  output logic               ld_error
);

  ld_state_e     state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;
  logic          hold_q, hold_d;
  logic          bit16_q, bit16_d;
  logic [7:0]    hi_q, hi_d;

  logic          xfer;
  logic          mem_we;
  instr_t        mem_wdata;
  logic [AW-1:0] raddr;
  instr_t        mem_rdata;
  logic          addr_hi;

  assign xfer = ld_valid && ld_ready;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_B0;
      wptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
      bit16_q <= 1'b0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      bit16_q <= bit16_d;
      hi_q    <= hi_d;
    end
  end

  // Next-state logic; the last word slot forces RUN so wptr never wraps
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_B0:  if (xfer) state_d = ld_last ? ST_RUN : ST_B1;
      ST_B1:  if (xfer) state_d = ld_last ? ST_RUN : ST_B2;
      ST_B2:  if (xfer) state_d = (ld_last || (&wptr_q)) ? ST_RUN : ST_B0;
      ST_RUN: state_d = ST_RUN;
      default: state_d = ST_B0;
    endcase
  end

  // Outputs and datapath updates
  always_comb begin
    ld_ready  = (state_q != ST_RUN);
    mem_we    = 1'b0;
    mem_wdata = {bit16_q, hi_q, ld_data};
    wptr_d    = wptr_q;
    count_d   = count_q;
    err_d     = err_q;
    bit16_d   = bit16_q;
    hi_d      = hi_q;
    hold_d    = (state_d != ST_RUN);
    if (xfer) begin
      unique case (state_q)
        ST_B0: begin
          bit16_d = ld_data[0];
          if ((ld_data[7:1] != '0) || ld_last) err_d = 1'b1;
        end
        ST_B1: begin
          hi_d = ld_data;
          if (ld_last) err_d = 1'b1;
        end
        ST_B2: begin
          mem_we  = 1'b1;
          count_d = count_q + (AW+1)'(1);
          if (!(&wptr_q)) wptr_d = wptr_q + AW'(1);
        end
        default: ;
      endcase
    end
  end

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clock   (clock),
    .we_i    (mem_we),
    .waddr_i (wptr_q),
    .wdata_i (mem_wdata),
    .raddr_i (raddr),
    .rdata_o (mem_rdata)
  );

  // Byte address to word index; anything above the array reads as NOP
  assign raddr     = imemaddr[AW:1];
  assign addr_hi   = (imemaddr >> (AW + 1)) != '0;
  assign imemrdata = (hold_q || addr_hi) ? NOP_WORD : mem_rdata;

  assign cpu_hold = hold_q;
  assign ld_count = count_q;
  assign ld_error = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal load, gapped stream, format errors,
// mid-load reset and a full-depth load, each with hand-computed expectations.
module tb_imem_loader;

  logic        clock;
  logic        reset;
  logic [15:0] imemaddr;
  logic [16:0] imemrdata;
  logic [7:0]  ld_data;
  logic        ld_valid;
  logic        ld_last;
  logic        ld_ready;
  logic        cpu_hold;
  logic [8:0]  ld_count;
  logic        ld_error;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [7:0]  wi;

  imem_loader #(
    .DEPTH (256),
    .AW    (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .imemaddr  (imemaddr),
    .imemrdata (imemrdata),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .cpu_hold  (cpu_hold),
    .ld_count  (ld_count),
    .ld_error  (ld_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    ld_valid = 1'b1;
    ld_data  = b;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Valid byte followed by an idle cycle carrying junk data and ld_last
  task automatic send_gap(input logic [7:0] b, input logic last);
    send(b, last);
    ld_data = 8'hFF;
    ld_last = 1'b1;
    tick();
    ld_last = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [15:0] a, input logic [16:0] exp);
    imemaddr = a;
    #1;
    check(tag, imemrdata, exp);
  endtask

  initial begin
    reset    = 1'b1;
    imemaddr = '0;
    ld_data  = '0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;

    // Reset state
    do_reset();
    check("rst_ready", ld_ready, 1);
    check("rst_hold",  cpu_hold, 1);
    check("rst_count", ld_count, 0);
    check("rst_error", ld_error, 0);
    read_chk("rst_rdata", 16'h0000, 17'h0);

    // Basic three-word load
    send(8'h00, 0); send(8'h12, 0); send(8'h34, 0);
    check("a_count1", ld_count, 1);
    send(8'h01, 0); send(8'hAB, 0); send(8'hCD, 0);
    send(8'h00, 0); send(8'h00, 0);
    check("a_hold_before_last", cpu_hold, 1);
    send(8'h07, 1);
    check("a_hold_after_last", cpu_hold, 0);
    check("a_ready", ld_ready, 0);
    check("a_count", ld_count, 3);
    check("a_error", ld_error, 0);
    read_chk("a_rd0", 16'h0000, 17'h01234);
    read_chk("a_rd2", 16'h0002, 17'h1ABCD);
    read_chk("a_rd4", 16'h0004, 17'h00007);
    read_chk("a_rd1_odd", 16'h0001, 17'h01234);
    read_chk("a_rd_oob", 16'h0200, 17'h0);

    // B0 byte with stray high bits: error, word still stored with bit16=0
    do_reset();
    send(8'h02, 0);
    check("b_error_b0", ld_error, 1);
    send(8'h55, 0); send(8'h66, 1);
    check("b_count", ld_count, 1);
    read_chk("b_rd0", 16'h0000, 17'h05566);

    // Same stream as the basic load, ld_valid toggled with junk on idle cycles
    do_reset();
    send_gap(8'h00, 0); send_gap(8'h12, 0);
    check("c_count0", ld_count, 0);
    send_gap(8'h34, 0);
    check("c_count1", ld_count, 1);
    send_gap(8'h01, 0); send_gap(8'hAB, 0);
    check("c_count1b", ld_count, 1);
    send_gap(8'hCD, 0);
    check("c_count2", ld_count, 2);
    send_gap(8'h00, 0); send_gap(8'h00, 0);
    check("c_ready", ld_ready, 1);
    send_gap(8'h07, 1);
    check("c_count3", ld_count, 3);
    check("c_hold", cpu_hold, 0);
    check("c_error", ld_error, 0);
    read_chk("c_rd0", 16'h0000, 17'h01234);
    read_chk("c_rd2", 16'h0002, 17'h1ABCD);
    read_chk("c_rd4", 16'h0004, 17'h00007);

    // ld_last on the second byte of word 1
    do_reset();
    send(8'h00, 0); send(8'h11, 0); send(8'h11, 0);
    send(8'h01, 0); send(8'h22, 1);
    check("d_error", ld_error, 1);
    check("d_count", ld_count, 1);
    check("d_ready", ld_ready, 0);
    check("d_hold",  cpu_hold, 0);
    read_chk("d_rd0", 16'h0000, 17'h01111);
    read_chk("d_rd2_kept", 16'h0002, 17'h1ABCD);

    // Reset after 1.5 words, then reload one word
    do_reset();
    send(8'h00, 0); send(8'hAA, 0); send(8'hBB, 0);
    read_chk("e_hold_rd0", 16'h0000, 17'h0);
    send(8'h01, 0); send(8'hCC, 0);
    read_chk("e_hold_rd2", 16'h0002, 17'h0);
    do_reset();
    check("e_rst_count", ld_count, 0);
    check("e_rst_error", ld_error, 0);
    read_chk("e_rst_rd0", 16'h0000, 17'h0);
    send(8'h01, 0); send(8'hFF, 0);
    read_chk("e_mid_rd0", 16'h0000, 17'h0);
    send(8'hFF, 1);
    check("e_count", ld_count, 1);
    check("e_error", ld_error, 0);
    read_chk("e_rd0", 16'h0000, 17'h1FFFF);
    read_chk("e_rd2_kept", 16'h0002, 17'h1ABCD);

    // Full-depth load without ld_last: word i = {i[0], i, ~i}
    do_reset();
    for (int unsigned i = 0; i < 255; i++) begin
      wi = i[7:0];
      send({7'b0, wi[0]}, 0); send(wi, 0); send(~wi, 0);
    end
    check("f_count255", ld_count, 255);
    check("f_ready255", ld_ready, 1);
    check("f_hold255",  cpu_hold, 1);
    send(8'h01, 0); send(8'hFF, 0); send(8'h00, 0);
    check("f_count", ld_count, 256);
    check("f_ready", ld_ready, 0);
    check("f_hold",  cpu_hold, 0);
    check("f_error", ld_error, 0);
    read_chk("f_rd0",   16'h0000, 17'h000FF);
    read_chk("f_rd127", 16'h00FF, 17'h17F80);
    read_chk("f_rd255", 16'h01FE, 17'h1FF00);
    read_chk("f_rd_oob",  16'h0200, 17'h0);
    read_chk("f_rd_top",  16'hFFFE, 17'h0);
    // Traffic in RUN must have no effect
    send(8'h01, 0); send(8'h55, 0); send(8'h55, 1);
    check("f_run_count", ld_count, 256);
    check("f_run_error", ld_error, 0);
    read_chk("f_run_rd0", 16'h0000, 17'h000FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 256, number of 17-bit instruction words held.
REQ-002 Parameter AW, default 8, word-index width; DEPTH = 2**AW.
REQ-003 clock  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 imemaddr  input  16  CPU byte address (PC), even-aligned.
REQ-006 imemrdata  output  17  instruction word returned to CPU.
REQ-007 ld_data  input  8  loader byte stream.
REQ-008 ld_valid  input  1  ld_data valid this cycle.
REQ-009 ld_last  input  1  qualifies current byte as final byte of the program.
REQ-010 ld_ready  output  1  loader can accept a byte this cycle.
REQ-011 cpu_hold  output  1  held high until the program is loaded; drives the CPU reset.
REQ-012 ld_count  output  AW+1  number of complete words written.
REQ-013 ld_error  output  1  sticky load-format error flag.

Function
REQ-014 Byte transfer SHALL occur only on cycles with ld_valid=1 and ld_ready=1; ld_data and ld_last are ignored otherwise.
REQ-015 The FSM SHALL have states B0, B1, B2 and RUN; ld_ready = 1 in B0/B1/B2 and 0 in RUN.
REQ-016 B0 transfer SHALL capture ld_data[0] as word bit 16 and advance to B1; nonzero ld_data[7:1] SHALL set ld_error.
REQ-017 B1 transfer SHALL capture ld_data as word bits 15:8 and advance to B2.
REQ-018 B2 transfer SHALL write {bit16, bits15:8, ld_data} into mem[wptr], increment wptr and ld_count, and return to B0.
REQ-019 ld_last on a B2 transfer SHALL complete that write and enter RUN.
REQ-020 ld_last on a B0 or B1 transfer SHALL discard the partial word, set ld_error, and enter RUN.
REQ-021 A B2 transfer that writes word DEPTH-1 SHALL enter RUN regardless of ld_last; wptr SHALL never wrap.
REQ-022 cpu_hold SHALL be a registered output equal to 1 in B0/B1/B2 and 0 from the first cycle the FSM is in RUN.
REQ-023 RUN SHALL be terminal until reset; ld_valid in RUN has no effect.
REQ-024 imemrdata SHALL be combinational: mem[imemaddr[AW:1]] when cpu_hold=0.
REQ-025 imemrdata SHALL be 17'h0 when imemaddr[15:AW+1] is nonzero.
REQ-026 imemrdata SHALL be 17'h0 while cpu_hold=1.
REQ-027 imemaddr[0] SHALL be ignored.
REQ-028 Words never written SHALL read as their previous contents; no clearing is performed.

Reset
REQ-029 Reset values: state = B0, wptr = 0, ld_count = 0, ld_error = 0, cpu_hold = 1, ld_ready = 1 from the first cycle after reset.
REQ-030 Reset mid-load SHALL discard any partial word and restart at word 0; already-written words SHALL be retained until overwritten.
REQ-031 Memory array contents SHALL NOT be reset.

Structure
REQ-032 FSM state encoding, the 17-bit instruction width, and a NOP_WORD = 17'h0 constant SHALL live in the shared project package.
REQ-033 Storage SHALL be one sub-module, imem_array: DEPTH x 17, one synchronous write port and one asynchronous read port.
REQ-034 FSM, byte assembly, and read-address decode SHALL reside in imem_loader.

Verification
REQ-035 Reset, then stream 3 words (00,12,34 / 01,AB,CD / 00,00,07 with ld_last on the final byte) -> ld_count = 3 and cpu_hold falls the cycle after the final transfer; imemaddr 0/2/4 return 17'h01234/17'h1ABCD/17'h00007.
REQ-036 ld_valid toggled 1/0 every cycle across the same stream -> identical contents; ld_count increments only on B2 transfers.
REQ-037 ld_last on the 2nd byte of word 1 -> ld_error = 1, ld_count = 1, RUN entered, mem[1] unchanged.
REQ-038 B0 byte = 8'h02 -> ld_error = 1 and the word is still stored with bit16 = 0.
REQ-039 Load DEPTH words without ld_last -> RUN entered after word DEPTH-1 and ld_ready = 0; imemaddr = 16'h0200 (AW = 8) returns 0.
REQ-040 Assert reset after 1.5 words, then reload 1 word (01,FF,FF, last) -> mem[0] = 17'h1FFFF, ld_count = 1, ld_error = 0; imemrdata = 0 throughout the hold.
